// File: rtl/sram_burst_reader_if.sv
// Handshake and SRAM pin bundle for sram_burst_reader.
// master = the reader controller, slave = consumer / SRAM side.
interface sram_burst_reader_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [15:0]       checksum;
  logic [ADDR_W-1:0] SRAM_ADDR;
  wire  [DATA_W-1:0] SRAM_DQ;
  logic              SRAM_WE_N;
  logic              SRAM_OE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_CE_N;

  modport master (
    input  start, start_addr, length, rd_ready,
    output busy, done, rd_data, rd_valid, checksum,
    output SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N,
    inout  SRAM_DQ
  );

  modport slave (
    output start, start_addr, length, rd_ready,
    input  busy, done, rd_data, rd_valid, checksum,
    input  SRAM_ADDR, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N,
    inout  SRAM_DQ
  );
endinterface

// File: rtl/sram_burst_reader.sv
// Burst read controller for the 256Kx16 async SRAM with valid/ready output.
// Optional running checksum enabled by defining SRAM_READER_CHECKSUM_EN.
module sram_burst_reader #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  sram_burst_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_VALID,
    S_FINISH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining;
  logic [3:0]        wait_cnt;
  logic              sram_en_n;

  // The reader never writes and never drives DQ; one enable covers all strobes.
  assign bus.SRAM_WE_N = 1'b1;
  assign bus.SRAM_OE_N = sram_en_n;
  assign bus.SRAM_CE_N = sram_en_n;
  assign bus.SRAM_UB_N = sram_en_n;
  assign bus.SRAM_LB_N = sram_en_n;
  assign bus.SRAM_ADDR = addr_q;

`ifdef SRAM_READER_CHECKSUM_EN
  logic [15:0] checksum_q;

  function automatic logic [15:0] sum16_wrap(input logic [15:0] acc,
                                             input logic [DATA_W-1:0] word);
    return acc + 16'(word);
  endfunction

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = 16'h0000;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
      sram_en_n    <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
`ifdef SRAM_READER_CHECKSUM_EN
      checksum_q   <= 16'h0000;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
`ifdef SRAM_READER_CHECKSUM_EN
            checksum_q <= 16'h0000;
`endif
            if (bus.length != '0) begin
              addr_q    <= bus.start_addr;
              remaining <= bus.length;
              sram_en_n <= 1'b0;
              bus.busy  <= 1'b1;
              state     <= S_ADDR;
            end else begin
              bus.done <= 1'b1;
              state    <= S_FINISH;
            end
          end
        end
        S_ADDR: begin
          wait_cnt <= 4'(WAIT_CYCLES);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Address and OE have been stable since the ADDR edge; sample on the last wait cycle.
          if (wait_cnt <= 4'd1) begin
            bus.rd_data  <= bus.SRAM_DQ;
            bus.rd_valid <= 1'b1;
            state        <= S_VALID;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_VALID: begin
          if (bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            remaining    <= remaining - 1'b1;
`ifdef SRAM_READER_CHECKSUM_EN
            checksum_q   <= sum16_wrap(checksum_q, bus.rd_data);
`endif
            if (remaining != {{(ADDR_W-1){1'b0}}, 1'b1}) begin
              addr_q <= addr_q + 1'b1;
              state  <= S_ADDR;
            end else begin
              sram_en_n <= 1'b1;
              bus.busy  <= 1'b0;
              bus.done  <= 1'b1;
              state     <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
